sysid_boot_checker: RTL and testbench

- Avalon-MM read master placed directly upstream of the platform system-ID slave; it reads both ID words and checks them against expected values.
- Word 0 is the system ID and word 1 is the build timestamp.
- After reset, and on every request, it reports pass/fail flags, the captured words and a saturating mismatch counter.
- Boot firmware and the status LEDs consume these outputs, so software can reject a stale or mismatched FPGA image.

---
 rtl/sysid_boot_checker.sv | 189 ++++++++++++++++++
 tb/tb_sysid_boot_checker.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sysid_boot_checker.sv
// sysid_boot_checker
//
// Reads the two words of the platform system-ID slave and checks them
// against the values expected for this image. Word 0 is the system ID and
// word 1 is the build timestamp.
//
// Ports:
//   clock_i            system clock
//   reset_i            synchronous, active-high reset
//   start_i            single-cycle check request; ignored while busy
//   sysid_address_o    word select to the slave (0 = ID, 1 = timestamp)
//   sysid_readdata_i   read data from the slave
//   busy_o             check in progress
//   done_o             last check complete; held until the next launch
//   id_ok_o            word 0 matched EXPECTED_ID
//   ts_ok_o            word 1 matched EXPECTED_TS
//   match_o            id_ok_o & ts_ok_o
//   read_id_o          captured word 0
//   read_ts_o          captured word 1
//   mismatch_count_o   completed checks that failed, saturating at 255
//
// Optional feature: define SYSID_BOOT_CHECKER_PERIODIC_EN to re-run the
// check every PERIOD clocks spent in IDLE/DONE. Without it, checks run only
// after reset (AUTO_START) or on start_i.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | no check run since reset; waiting for start or auto launch
// RD_ID  | address 0 driven, waiting out the latency, then capture ID
// RD_TS  | address 1 driven, waiting out the latency, then capture TS
// CMP    | compare captured words, update flags and mismatch counter
// DONE   | results valid and held; waiting for the next launch

module sysid_boot_checker #(
   parameter logic [31:0] EXPECTED_ID  = 32'h12345678,
   parameter logic [31:0] EXPECTED_TS  = 32'd1555426020,
   parameter int unsigned READ_LATENCY = 1,
   parameter bit          AUTO_START   = 1'b1,
   parameter int unsigned PERIOD       = 50000000
) (
   input  logic        clock_i,
   input  logic        reset_i,
   input  logic        start_i,
   output logic        sysid_address_o,
   input  logic [31:0] sysid_readdata_i,
   output logic        busy_o,
   output logic        done_o,
   output logic        id_ok_o,
   output logic        ts_ok_o,
   output logic        match_o,
   output logic [31:0] read_id_o,
   output logic [31:0] read_ts_o,
   output logic [7:0]  mismatch_count_o
);

   localparam logic [3:0] LAT = 4'(READ_LATENCY);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD_ID,
      S_RD_TS,
      S_CMP,
      S_DONE
   } state_t;

   state_t      state_q;
   logic [3:0]  lat_q;
   logic        pend_q;
   logic        addr_q;
   logic        busy_q;
   logic        done_q;
   logic        id_ok_q;
   logic        ts_ok_q;
   logic        match_q;
   logic [31:0] read_id_q;
   logic [31:0] read_ts_q;
   logic [7:0]  mis_cnt_q;

   logic launch_d;
   logic id_ok_d;
   logic ts_ok_d;

`ifdef SYSID_BOOT_CHECKER_PERIODIC_EN
   localparam int PW = (PERIOD > 2) ? $clog2(PERIOD) : 1;
   logic [PW-1:0] per_q;
   logic          per_tick_d;
   assign per_tick_d = (per_q == PW'(PERIOD - 1));
`endif

   assign launch_d = start_i | pend_q;
   assign id_ok_d  = (read_id_q == EXPECTED_ID);
   assign ts_ok_d  = (read_ts_q == EXPECTED_TS);

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         state_q   <= S_IDLE;
         lat_q     <= 4'd0;
         pend_q    <= AUTO_START;
         addr_q    <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         id_ok_q   <= 1'b0;
         ts_ok_q   <= 1'b0;
         match_q   <= 1'b0;
         read_id_q <= 32'd0;
         read_ts_q <= 32'd0;
         mis_cnt_q <= 8'd0;
`ifdef SYSID_BOOT_CHECKER_PERIODIC_EN
         per_q     <= '0;
`endif
      end else begin
         case (state_q)
            S_IDLE, S_DONE: begin
               if (launch_d) begin
                  // A periodic tick in the same cycle as start_i is absorbed
                  // here: the pending flag is cleared, so only one check runs.
                  state_q <= S_RD_ID;
                  pend_q  <= 1'b0;
                  busy_q  <= 1'b1;
                  done_q  <= 1'b0;
                  id_ok_q <= 1'b0;
                  ts_ok_q <= 1'b0;
                  match_q <= 1'b0;
                  lat_q   <= LAT;
                  addr_q  <= 1'b0;
`ifdef SYSID_BOOT_CHECKER_PERIODIC_EN
                  per_q   <= '0;
`endif
               end
`ifdef SYSID_BOOT_CHECKER_PERIODIC_EN
               else if (per_tick_d) begin
                  pend_q <= 1'b1;
                  per_q  <= '0;
               end else begin
                  per_q <= per_q + 1'b1;
               end
`endif
            end
            S_RD_ID: begin
               addr_q <= 1'b0;
               if (lat_q != 4'd0) begin
                  lat_q <= lat_q - 4'd1;
               end else begin
                  read_id_q <= sysid_readdata_i;
                  lat_q     <= LAT;
                  addr_q    <= 1'b1;
                  state_q   <= S_RD_TS;
               end
            end
            S_RD_TS: begin
               addr_q <= 1'b1;
               if (lat_q != 4'd0) begin
                  lat_q <= lat_q - 4'd1;
               end else begin
                  read_ts_q <= sysid_readdata_i;
                  lat_q     <= LAT;
                  state_q   <= S_CMP;
               end
            end
            S_CMP: begin
               id_ok_q <= id_ok_d;
               ts_ok_q <= ts_ok_d;
               match_q <= id_ok_d & ts_ok_d;
               if (!(id_ok_d && ts_ok_d) && (mis_cnt_q != 8'hFF)) begin
                  mis_cnt_q <= mis_cnt_q + 8'd1;
               end
               busy_q  <= 1'b0;
               done_q  <= 1'b1;
               addr_q  <= 1'b0;
               state_q <= S_DONE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign sysid_address_o  = addr_q;
   assign busy_o           = busy_q;
   assign done_o           = done_q;
   assign id_ok_o          = id_ok_q;
   assign ts_ok_o          = ts_ok_q;
   assign match_o          = match_q;
   assign read_id_o        = read_id_q;
   assign read_ts_o        = read_ts_q;
   assign mismatch_count_o = mis_cnt_q;

endmodule

// File: tb/tb_sysid_boot_checker.sv
// Testbench for sysid_boot_checker (default build, periodic feature off).
// A stimulus process programs a behavioural slave, predicts the outcome of
// each check and queues it; a monitor pops and compares whenever done rises.

module tb_sysid_boot_checker;

   localparam logic [31:0] EXP_ID = 32'h12345678;
   localparam logic [31:0] EXP_TS = 32'd1555426020;
   localparam int          RL     = 1;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        addr;
   logic [31:0] rdata;
   logic [31:0] slv_id = EXP_ID;
   logic [31:0] slv_ts = EXP_TS;
   logic        busy, done, id_ok, ts_ok, match;
   logic [31:0] read_id, read_ts;
   logic [7:0]  mcount;

   always #5 clk = ~clk;

   // Behavioural slave: word select picks which stored word is returned.
   assign rdata = addr ? slv_ts : slv_id;

   sysid_boot_checker #(
      .EXPECTED_ID (EXP_ID),
      .EXPECTED_TS (EXP_TS),
      .READ_LATENCY(RL),
      .AUTO_START  (1'b1),
      .PERIOD      (20)
   ) dut (
      .clock_i         (clk),
      .reset_i         (rst),
      .start_i         (start),
      .sysid_address_o (addr),
      .sysid_readdata_i(rdata),
      .busy_o          (busy),
      .done_o          (done),
      .id_ok_o         (id_ok),
      .ts_ok_o         (ts_ok),
      .match_o         (match),
      .read_id_o       (read_id),
      .read_ts_o       (read_ts),
      .mismatch_count_o(mcount)
   );

   typedef struct {
      logic [31:0] id;
      logic [31:0] ts;
      logic        id_ok;
      logic        ts_ok;
      logic        match;
      logic [7:0]  cnt;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   model_cnt = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, expv, $time);
      end
   endtask

   // Reference model: the outcome follows directly from the stored words.
   task automatic push_expected();
      exp_t e;
      e.id    = slv_id;
      e.ts    = slv_ts;
      e.id_ok = (slv_id == EXP_ID);
      e.ts_ok = (slv_ts == EXP_TS);
      e.match = e.id_ok && e.ts_ok;
      if (!e.match) model_cnt = (model_cnt >= 255) ? 255 : model_cnt + 1;
      e.cnt = 8'(model_cnt);
      exp_q.push_back(e);
   endtask

   // kind: 0 good, 1 bad ID, 2 bad timestamp, 3 both bad
   task automatic set_slave(input int kind);
      slv_id = EXP_ID;
      slv_ts = EXP_TS;
      if (kind == 1 || kind == 3) slv_id = EXP_ID ^ (32'd1 << $urandom_range(31));
      if (kind == 2 || kind == 3) slv_ts = EXP_TS + 32'($urandom_range(1000, 1));
   endtask

   task automatic wait_done();
      int n = 0;
      while (!done && n < 60) begin
         @(negedge clk);
         n++;
      end
      if (n >= 60) chk("done_timeout", 32'd1, 32'd0);
   endtask

   task automatic run_check();
      @(posedge clk); #1;
      push_expected();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_done();
   endtask

   task automatic check_reset_values();
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_addr", 32'(addr), 32'd0);
      chk("rst_id_ok", 32'(id_ok), 32'd0);
      chk("rst_ts_ok", 32'(ts_ok), 32'd0);
      chk("rst_match", 32'(match), 32'd0);
      chk("rst_read_id", read_id, 32'd0);
      chk("rst_read_ts", read_ts, 32'd0);
      chk("rst_count", 32'(mcount), 32'd0);
   endtask

   // Monitor: measures busy duration and address phases, and compares the
   // result registers against the queued prediction when done rises.
   int   bcnt = 0;
   int   a1cnt = 0;
   logic done_prev = 1'b0;
   exp_t mon_e;

   always @(negedge clk) begin
      if (rst) begin
         bcnt  = 0;
         a1cnt = 0;
      end else begin
         if (busy) begin
            bcnt++;
            if (addr) a1cnt++;
         end
         if (done && !done_prev) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_done", 32'd1, 32'd0);
            end else begin
               mon_e = exp_q.pop_front();
               chk("read_id", read_id, mon_e.id);
               chk("read_ts", read_ts, mon_e.ts);
               chk("id_ok", 32'(id_ok), 32'(mon_e.id_ok));
               chk("ts_ok", 32'(ts_ok), 32'(mon_e.ts_ok));
               chk("match", 32'(match), 32'(mon_e.match));
               chk("mismatch_count", 32'(mcount), 32'(mon_e.cnt));
               chk("busy_cycles", 32'(bcnt), 32'(2 * (RL + 1) + 1));
               chk("addr1_cycles", 32'(a1cnt), 32'(RL + 2));
               chk("busy_at_done", 32'(busy), 32'd0);
            end
            bcnt  = 0;
            a1cnt = 0;
         end
      end
      done_prev = done;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int idle_busy;

      // Reset state, then the automatic check after release.
      set_slave(0);
      repeat (3) @(posedge clk);
      #1;
      check_reset_values();
      push_expected();
      rst = 1'b0;
      wait_done();

      // Word 0 off by one.
      slv_id = 32'h12345679;
      slv_ts = EXP_TS;
      run_check();

      // start in the second busy cycle is ignored.
      set_slave(0);
      @(posedge clk); #1;
      push_expected();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_done();
      repeat (10) @(posedge clk);

      // Randomised mix of outcomes.
      for (int i = 0; i < 40; i++) begin
         set_slave(int'($urandom_range(3)));
         run_check();
      end

      // Reset during RD_TS, with a coincident start that must lose.
      set_slave(3);
      @(posedge clk); #1;
      push_expected();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      begin
         int n = 0;
         while (!addr && n < 20) begin
            @(posedge clk); #1;
            n++;
         end
         if (n >= 20) chk("reach_rd_ts_timeout", 32'd1, 32'd0);
      end
      rst   = 1'b1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check_reset_values();
      exp_q.delete();
      model_cnt = 0;
      set_slave(1);
      push_expected();
      rst = 1'b0;
      wait_done();

      // Saturation of the mismatch counter.
      for (int i = 0; i < 258; i++) begin
         set_slave(int'($urandom_range(3, 1)));
         run_check();
      end
      chk("count_saturated", 32'(mcount), 32'd255);

      // No further launch without a request.
      idle_busy = 0;
      repeat (100) begin
         @(negedge clk);
         if (busy) idle_busy++;
      end
      chk("no_relaunch", 32'(idle_busy), 32'd0);
      chk("queue_drained", 32'(exp_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
